// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary and the ID/EX register.
package if_id_stage_pkg;

  localparam int BUS_WIDTH_DEF   = 64;
  localparam int INSTR_WIDTH_DEF = 32;

  // addi x0,x0,0
  localparam logic [INSTR_WIDTH_DEF-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [BUS_WIDTH_DEF-1:0]   pc;
    logic [INSTR_WIDTH_DEF-1:0] instr;
    logic                       valid;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: fetch-side inputs and the decode-slot outputs.
interface if_id_stage_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   stall;
  logic                   flush;
  logic [BUS_WIDTH-1:0]   if_pc;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [BUS_WIDTH-1:0]   id_pc;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic                   id_valid;
  logic [BUS_WIDTH-1:0]   id_instr_cnt;
  logic [BUS_WIDTH-1:0]   id_bubble_cnt;

  modport master (
    output stall, flush, if_pc, if_instr,
    input  id_pc, id_instr, id_valid, id_instr_cnt, id_bubble_cnt
  );

  modport slave (
    input  stall, flush, if_pc, if_instr,
    output id_pc, id_instr, id_valid, id_instr_cnt, id_bubble_cnt
  );
endinterface

// File: rtl/if_id_stage_instr_hold_buf.sv
// Instruction hold buffer: captures memory read data on the first stalled edge so
// the decode slot keeps its instruction while memory re-reads the frozen address.
module instr_hold_buf #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [INSTR_WIDTH-1:0] if_instr_i,
  output logic [INSTR_WIDTH-1:0] instr_o
);

  logic                   hold_sel_q, hold_sel_d;
  logic [INSTR_WIDTH-1:0] instr_hold_q, instr_hold_d;

  // Next-state: flush drops any held copy; first stalled edge captures; release clears.
  always_comb begin
    hold_sel_d   = hold_sel_q;
    instr_hold_d = instr_hold_q;
    if (flush_i) begin
      hold_sel_d = 1'b0;
    end else if (stall_i) begin
      if (!hold_sel_q) begin
        instr_hold_d = if_instr_i;
        hold_sel_d   = 1'b1;
      end
    end else begin
      hold_sel_d = 1'b0;
    end
  end

  // Capture register and select flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_sel_q   <= 1'b0;
      instr_hold_q <= '0;
    end else begin
      hold_sel_q   <= hold_sel_d;
      instr_hold_q <= instr_hold_d;
    end
  end

  assign instr_o = hold_sel_q ? instr_hold_q : if_instr_i;

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode boundary stage. Realigns the fetch PC with one-cycle-late
// instruction memory data, holds across stalls, kills on redirect and counts
// delivered instructions and bubbles.
// Optional build macro IF_ID_NOP_INJECT_EN: drive NOP_INSTR on invalid slots.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  if_id_stage_if.slave  bus
);

  logic [BUS_WIDTH-1:0]   slot_pc_q, slot_pc_d;
  logic                   slot_valid_q, slot_valid_d;
  logic [BUS_WIDTH-1:0]   instr_cnt_q, instr_cnt_d;
  logic [BUS_WIDTH-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [INSTR_WIDTH-1:0] raw_instr;

  instr_hold_buf #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (bus.stall),
    .flush_i    (bus.flush),
    .if_instr_i (bus.if_instr),
    .instr_o    (raw_instr)
  );

  // Slot and counter next-state: flush kills (even when stalled), else advance unless stalled.
  always_comb begin
    slot_pc_d    = slot_pc_q;
    slot_valid_d = slot_valid_q;
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush) begin
      slot_pc_d    = bus.if_pc;
      slot_valid_d = 1'b0;
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else if (!bus.stall) begin
      slot_pc_d    = bus.if_pc;
      slot_valid_d = 1'b1;
      instr_cnt_d  = instr_cnt_q + 1'b1;
    end
  end

  // Slot and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_pc_q    <= '0;
      slot_valid_q <= 1'b0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      slot_pc_q    <= slot_pc_d;
      slot_valid_q <= slot_valid_d;
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.id_pc         = slot_pc_q;
  assign bus.id_valid      = slot_valid_q;
  assign bus.id_instr_cnt  = instr_cnt_q;
  assign bus.id_bubble_cnt = bubble_cnt_q;

`ifdef IF_ID_NOP_INJECT_EN
  assign bus.id_instr = slot_valid_q ? raw_instr : INSTR_WIDTH'(NOP_INSTR);
`else
  assign bus.id_instr = raw_instr;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a small fetch-PC and instruction-memory model
// (I[k] = 0x1000 + k, one-cycle read latency).
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [63:0] pc_q;
  logic [63:0] target;
  logic [31:0] mem_data;
  int          n_checks;
  int          n_errors;

  if_id_stage_if #(.BUS_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  if_id_stage #(.BUS_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch PC: redirect loads the target on the flush edge, stall freezes it.
  always @(posedge clk) begin
    if (rst)            pc_q <= '0;
    else if (bus.flush) pc_q <= target;
    else if (!bus.stall) pc_q <= pc_q + 64'd4;
  end

  // Instruction memory: data for the address presented at the previous edge.
  always @(posedge clk) mem_data <= 32'h1000 + 32'(bus.if_pc >> 2);

  assign bus.if_pc    = pc_q;
  assign bus.if_instr = mem_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                      input logic valid);
    check({tag, ".pc"},    bus.id_pc, pc);
    check({tag, ".instr"}, 64'(bus.id_instr), 64'(instr));
    check({tag, ".valid"}, 64'(bus.id_valid), 64'(valid));
  endtask

  task automatic cnts(input string tag, input logic [63:0] ic, input logic [63:0] bc);
    check({tag, ".icnt"}, bus.id_instr_cnt, ic);
    check({tag, ".bcnt"}, bus.id_bubble_cnt, bc);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    target    = '0;

    // Reset state
    step(); step();
    check("rst.pc", bus.id_pc, 64'h0);
    check("rst.valid", 64'(bus.id_valid), 64'h0);
    cnts("rst", 64'd0, 64'd0);
`ifdef IF_ID_NOP_INJECT_EN
    check("rst.nop", 64'(bus.id_instr), 64'h13);
`endif

    // Release: one-edge latency, no extra bubble
    rst = 1'b0;
    step();
    slot("c1", 64'h0, 32'h1000, 1'b1);
    step(); step();
    slot("c3", 64'h8, 32'h1002, 1'b1);
    cnts("c3", 64'd3, 64'd0);
    step(); step();
    slot("c5", 64'h10, 32'h1004, 1'b1);

    // Stall three edges while slot holds 0x10
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      slot("stall", 64'h10, 32'h1004, 1'b1);
    end
    cnts("stall", 64'd5, 64'd0);
    bus.stall = 1'b0;
    step();
    slot("rel", 64'h14, 32'h1005, 1'b1);
    cnts("rel", 64'd6, 64'd0);

    // Flush to 0x40 while slot holds 0x8
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();
    slot("pre_fl", 64'h8, 32'h1002, 1'b1);
    bus.flush = 1'b1;
    target    = 64'h40;
    step();
    bus.flush = 1'b0;
    check("fl.valid", 64'(bus.id_valid), 64'h0);
    cnts("fl", 64'd3, 64'd1);
`ifdef IF_ID_NOP_INJECT_EN
    check("fl.nop", 64'(bus.id_instr), 64'h13);
`endif
    step();
    slot("tgt", 64'h40, 32'h1010, 1'b1);
    cnts("tgt", 64'd4, 64'd1);
    step();
    slot("tgt1", 64'h44, 32'h1011, 1'b1);

    // Stall (arms hold), then stall+flush together, then release
    bus.stall = 1'b1;
    step();
    slot("sf_st", 64'h44, 32'h1011, 1'b1);
    bus.flush = 1'b1;
    target    = 64'h80;
    step();
    check("sf.valid", 64'(bus.id_valid), 64'h0);
    cnts("sf", 64'd5, 64'd2);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    step();
    slot("sf_rel", 64'h80, 32'h1020, 1'b1);
    cnts("sf_rel", 64'd6, 64'd2);

    // Reset during an active stall
    bus.stall = 1'b1;
    step();
    slot("rs_st", 64'h80, 32'h1020, 1'b1);
    rst = 1'b1;
    step();
    check("rs.pc", bus.id_pc, 64'h0);
    check("rs.valid", 64'(bus.id_valid), 64'h0);
    cnts("rs", 64'd0, 64'd0);
    rst       = 1'b0;
    bus.stall = 1'b0;
    step();
    slot("rs_rel", 64'h0, 32'h1000, 1'b1);
    cnts("rs_rel", 64'd1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
